pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_seq_pkg.sv | 28 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: the sequencer
// state encoding, a counter-width helper and the default timing constants.
package pll_reset_seq_pkg;

   // Sequencer states, from PLL reset through lock qualification to run.
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } seq_state_e;

   // Bits needed for a counter that must be able to hold max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Default timing for the 74.25 MHz reference clock.
   localparam int DEF_NUM_DOMAINS    = 5;
   localparam int DEF_RST_CYCLES     = 16;
   localparam int DEF_LOCK_TIMEOUT   = 1048576;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_STAGGER_CYCLES = 64;
   localparam int DEF_MAX_RETRIES    = 7;

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Brings an asynchronous level into the clk_i domain with two cycles
// of latency; the reset value of both stages is zero.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // First stage may go metastable; the second stage gives it a cycle to settle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock with a
// timeout/retry budget, then releases per-domain resets one at a time.
// Loss of lock in RELEASE/RUN drops every domain and restarts the sequence.
// Optional feature macro PLLSEQ_LOSS_COUNT_EN adds lock_loss_cnt_o, an
// 8-bit saturating count of lock-loss events cleared only by rst_n.
module pll_reset_sequencer
   import pll_reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int RST_CYCLES     = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   pll_locked_i,
   input  logic                   req_reset_i,
   output logic                   pll_rst_o,
   output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
   output logic                   ready_o,
   output logic                   fault_o,
   output logic [3:0]             retry_cnt_o
`ifdef PLLSEQ_LOSS_COUNT_EN
   ,
   output logic [7:0]             lock_loss_cnt_o
`endif
);

   localparam int RST_W = cnt_width(RST_CYCLES);
   localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
   localparam int STB_W = cnt_width(STABLE_CYCLES);
   localparam int STG_W = cnt_width(STAGGER_CYCLES);

   // Terminal values are one less than the cycle counts because each
   // counter starts at zero on the first cycle of its interval.
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);
   localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1);

   seq_state_e             state_q;
   logic [RST_W-1:0]       rst_cnt_q;
   logic [TMO_W-1:0]       tmo_cnt_q;
   logic [STB_W-1:0]       stab_cnt_q;
   logic [STG_W-1:0]       stag_cnt_q;
   logic                   pll_rst_q;
   logic [NUM_DOMAINS-1:0] dom_q;
   logic                   ready_q;
   logic                   fault_q;
   logic [3:0]             retry_q;

   logic       locked_s;
   logic       timeout_hit;
   logic       lock_loss;
   logic [3:0] retry_inc;
   logic       retry_exhausted;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk_i  (refclk),
      .rst_ni (rst_n),
      .d_i    (pll_locked_i),
      .q_o    (locked_s)
   );

   assign timeout_hit     = (tmo_cnt_q == TMO_LAST);
   assign lock_loss       = ((state_q == RELEASE) || (state_q == RUN)) && !locked_s && !req_reset_i;
   assign retry_inc       = (retry_q == 4'hF) ? 4'hF : (retry_q + 4'd1);
   assign retry_exhausted = (int'({28'd0, retry_inc}) == MAX_RETRIES);

   // Sequencer FSM; every output is a register so the domain resets never glitch.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_PLL;
         rst_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         stab_cnt_q <= '0;
         stag_cnt_q <= '0;
         pll_rst_q  <= 1'b1;
         dom_q      <= '0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
         retry_q    <= '0;
      end else if (req_reset_i) begin
         state_q    <= RESET_PLL;
         rst_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         stab_cnt_q <= '0;
         stag_cnt_q <= '0;
         pll_rst_q  <= 1'b1;
         dom_q      <= '0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
         retry_q    <= '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               pll_rst_q  <= 1'b1;
               dom_q      <= '0;
               ready_q    <= 1'b0;
               fault_q    <= 1'b0;
               tmo_cnt_q  <= '0;
               stab_cnt_q <= '0;
               stag_cnt_q <= '0;
               if (rst_cnt_q == RST_LAST) begin
                  state_q   <= WAIT_LOCK;
                  pll_rst_q <= 1'b0;
                  rst_cnt_q <= '0;
               end else begin
                  rst_cnt_q <= rst_cnt_q + RST_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s && (STABLE_CYCLES <= 1)) begin
                  state_q    <= RELEASE;
                  dom_q      <= DOM_FIRST;
                  stag_cnt_q <= '0;
               end else if (timeout_hit) begin
                  retry_q    <= retry_inc;
                  rst_cnt_q  <= '0;
                  tmo_cnt_q  <= '0;
                  stab_cnt_q <= '0;
                  pll_rst_q  <= 1'b1;
                  if (retry_exhausted) begin
                     state_q <= FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= RESET_PLL;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                  if (locked_s) begin
                     state_q    <= STABLE;
                     stab_cnt_q <= STB_W'(1);
                  end
               end
            end
            STABLE: begin
               if (locked_s && (stab_cnt_q == STB_LAST)) begin
                  state_q    <= RELEASE;
                  dom_q      <= DOM_FIRST;
                  stag_cnt_q <= '0;
               end else if (timeout_hit) begin
                  retry_q    <= retry_inc;
                  rst_cnt_q  <= '0;
                  tmo_cnt_q  <= '0;
                  stab_cnt_q <= '0;
                  pll_rst_q  <= 1'b1;
                  if (retry_exhausted) begin
                     state_q <= FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= RESET_PLL;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                  if (locked_s) begin
                     stab_cnt_q <= stab_cnt_q + STB_W'(1);
                  end else begin
                     state_q    <= WAIT_LOCK;
                     stab_cnt_q <= '0;
                  end
               end
            end
            RELEASE: begin
               if (lock_loss) begin
                  state_q    <= RESET_PLL;
                  pll_rst_q  <= 1'b1;
                  dom_q      <= '0;
                  ready_q    <= 1'b0;
                  rst_cnt_q  <= '0;
                  tmo_cnt_q  <= '0;
                  stab_cnt_q <= '0;
                  stag_cnt_q <= '0;
               end else if (&dom_q) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else if (stag_cnt_q == STG_LAST) begin
                  dom_q      <= (dom_q << 1) | DOM_FIRST;
                  stag_cnt_q <= '0;
               end else begin
                  stag_cnt_q <= stag_cnt_q + STG_W'(1);
               end
            end
            RUN: begin
               if (lock_loss) begin
                  state_q    <= RESET_PLL;
                  pll_rst_q  <= 1'b1;
                  dom_q      <= '0;
                  ready_q    <= 1'b0;
                  rst_cnt_q  <= '0;
                  tmo_cnt_q  <= '0;
                  stab_cnt_q <= '0;
                  stag_cnt_q <= '0;
               end
            end
            FAULT: begin
               pll_rst_q <= 1'b1;
               dom_q     <= '0;
               ready_q   <= 1'b0;
               fault_q   <= 1'b1;
            end
            default: begin
               state_q    <= RESET_PLL;
               rst_cnt_q  <= '0;
               tmo_cnt_q  <= '0;
               stab_cnt_q <= '0;
               stag_cnt_q <= '0;
               pll_rst_q  <= 1'b1;
               dom_q      <= '0;
               ready_q    <= 1'b0;
               fault_q    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLLSEQ_LOSS_COUNT_EN
   logic [7:0] loss_cnt_q;

   // Saturating lock-loss event counter; survives req_reset so field history is kept.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt_q <= '0;
      end else if (lock_loss && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign lock_loss_cnt_o = loss_cnt_q;
`endif

   assign pll_rst_o   = pll_rst_q;
   assign dom_rst_n_o = dom_q;
   assign ready_o     = ready_q;
   assign fault_o     = fault_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with shortened timing parameters.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge and compared both against hand-derived vectors and against a
// cycle-level reference model built from elapsed-time arithmetic.
module tb_pll_reset_sequencer;

   localparam int N_DOM  = 5;
   localparam int T_RST  = 4;
   localparam int T_TMO  = 100;
   localparam int T_STAB = 8;
   localparam int T_STAG = 2;
   localparam int N_RETRY = 3;

   localparam int PH_RST     = 0;
   localparam int PH_LOCKING = 1;
   localparam int PH_REL     = 2;
   localparam int PH_RUN     = 3;
   localparam int PH_FAULT   = 4;

   logic             refclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pll_locked = 1'b0;
   logic             req_reset = 1'b0;
   logic             pll_rst;
   logic [N_DOM-1:0] dom_rst_n;
   logic             ready;
   logic             fault;
   logic [3:0]       retry_cnt;
`ifdef PLLSEQ_LOSS_COUNT_EN
   logic [7:0]       lock_loss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: phase plus elapsed-cycle counters.
   int   mPhase;
   int   mAge;
   int   mTmo;
   int   mRun;
   int   mRelAge;
   int   mRetry;
   int   mLoss;
   logic lockPipe[$];

   typedef struct {
      logic             lock;
      int               steps;
      logic             expPllRst;
      logic [N_DOM-1:0] expDom;
      logic             expReady;
   } vec_t;

   vec_t vecs[10];

   pll_reset_sequencer #(
      .NUM_DOMAINS    (N_DOM),
      .RST_CYCLES     (T_RST),
      .LOCK_TIMEOUT   (T_TMO),
      .STABLE_CYCLES  (T_STAB),
      .STAGGER_CYCLES (T_STAG),
      .MAX_RETRIES    (N_RETRY)
   ) dut (
      .refclk          (refclk),
      .rst_n           (rst_n),
      .pll_locked_i    (pll_locked),
      .req_reset_i     (req_reset),
      .pll_rst_o       (pll_rst),
      .dom_rst_n_o     (dom_rst_n),
      .ready_o         (ready),
      .fault_o         (fault),
      .retry_cnt_o     (retry_cnt)
`ifdef PLLSEQ_LOSS_COUNT_EN
      ,
      .lock_loss_cnt_o (lock_loss_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mPhase  = PH_RST;
      mAge    = 0;
      mTmo    = 0;
      mRun    = 0;
      mRelAge = 0;
      mRetry  = 0;
      mLoss   = 0;
      lockPipe.delete();
      lockPipe.push_back(1'b0);
      lockPipe.push_back(1'b0);
   endfunction

   function automatic int modelReleased();
      int k;
      k = mRelAge / T_STAG + 1;
      if (k > N_DOM) k = N_DOM;
      return k;
   endfunction

   function automatic logic [N_DOM-1:0] modelDom();
      int v;
      v = 0;
      if (mPhase == PH_REL) v = (1 << modelReleased()) - 1;
      else if (mPhase == PH_RUN) v = (1 << N_DOM) - 1;
      return N_DOM'(v);
   endfunction

   function automatic void modelLoss();
      mPhase = PH_RST;
      mAge   = 0;
      if (mLoss < 255) mLoss++;
   endfunction

   // One rising edge of the reference model, using the pre-edge inputs.
   function automatic void modelStep(input logic lockIn, input logic reqIn);
      logic ls;
      ls = lockPipe[0];
      if (reqIn) begin
         mPhase = PH_RST;
         mAge   = 0;
         mRetry = 0;
      end else begin
         case (mPhase)
            PH_RST: begin
               mAge++;
               if (mAge == T_RST) begin
                  mPhase = PH_LOCKING;
                  mTmo   = 0;
                  mRun   = 0;
               end
            end
            PH_LOCKING: begin
               mTmo++;
               mRun = ls ? mRun + 1 : 0;
               if (mRun >= T_STAB) begin
                  mPhase  = PH_REL;
                  mRelAge = 0;
               end else if (mTmo >= T_TMO) begin
                  mRetry = (mRetry >= 15) ? 15 : mRetry + 1;
                  if (mRetry == N_RETRY) mPhase = PH_FAULT;
                  else begin
                     mPhase = PH_RST;
                     mAge   = 0;
                  end
               end
            end
            PH_REL: begin
               if (!ls) modelLoss();
               else if (modelReleased() == N_DOM) mPhase = PH_RUN;
               else mRelAge++;
            end
            PH_RUN: if (!ls) modelLoss();
            default: ;
         endcase
      end
      void'(lockPipe.pop_front());
      lockPipe.push_back(lockIn);
   endfunction

   task automatic checkOutput();
      checkVal("m_pll_rst", pll_rst, (mPhase == PH_RST || mPhase == PH_FAULT));
      checkVal("m_dom_rst_n", dom_rst_n, modelDom());
      checkVal("m_ready", ready, (mPhase == PH_RUN));
      checkVal("m_fault", fault, (mPhase == PH_FAULT));
      checkVal("m_retry_cnt", retry_cnt, mRetry);
`ifdef PLLSEQ_LOSS_COUNT_EN
      checkVal("m_lock_loss_cnt", lock_loss_cnt, mLoss);
`endif
   endtask

   task automatic applyStimulus(input logic lock, input logic req);
      @(negedge refclk);
      pll_locked = lock;
      req_reset  = req;
      @(posedge refclk);
      modelStep(lock, req);
      #1;
      checkOutput();
   endtask

   task automatic measureHigh(input logic lock, output int n);
      n = 0;
      while (pll_rst === 1'b1 && n < 200) begin
         applyStimulus(lock, 1'b0);
         n++;
      end
   endtask

   task automatic measureLow(output int n);
      n = 0;
      while (pll_rst === 1'b0 && n < 300) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
   endtask

   task automatic waitReady(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         applyStimulus(1'b1, 1'b0);
         n++;
      end
   endtask

   task automatic doReset();
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      req_reset  = 1'b0;
      modelReset();
      repeat (3) @(posedge refclk);
      #1;
      checkVal("rst_pll_rst", pll_rst, 1);
      checkVal("rst_dom_rst_n", dom_rst_n, 0);
      checkVal("rst_ready", ready, 0);
      checkVal("rst_fault", fault, 0);
      checkVal("rst_retry_cnt", retry_cnt, 0);
      rst_n = 1'b1;
   endtask

   // Safety net in case some wait is never satisfied.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int spanLeft;
      logic lvl;

      // Normal lock: lock rises 10 cycles into WAIT_LOCK (times relative to pll_rst fall).
      vecs[0] = '{lock: 1'b0, steps: 10, expPllRst: 1'b0, expDom: 5'b00000, expReady: 1'b0};
      vecs[1] = '{lock: 1'b1, steps: 9,  expPllRst: 1'b0, expDom: 5'b00000, expReady: 1'b0};
      vecs[2] = '{lock: 1'b1, steps: 1,  expPllRst: 1'b0, expDom: 5'b00001, expReady: 1'b0};
      vecs[3] = '{lock: 1'b1, steps: 1,  expPllRst: 1'b0, expDom: 5'b00001, expReady: 1'b0};
      vecs[4] = '{lock: 1'b1, steps: 1,  expPllRst: 1'b0, expDom: 5'b00011, expReady: 1'b0};
      vecs[5] = '{lock: 1'b1, steps: 2,  expPllRst: 1'b0, expDom: 5'b00111, expReady: 1'b0};
      vecs[6] = '{lock: 1'b1, steps: 2,  expPllRst: 1'b0, expDom: 5'b01111, expReady: 1'b0};
      vecs[7] = '{lock: 1'b1, steps: 2,  expPllRst: 1'b0, expDom: 5'b11111, expReady: 1'b0};
      vecs[8] = '{lock: 1'b1, steps: 1,  expPllRst: 1'b0, expDom: 5'b11111, expReady: 1'b1};
      vecs[9] = '{lock: 1'b1, steps: 5,  expPllRst: 1'b0, expDom: 5'b11111, expReady: 1'b1};

      doReset();
      measureHigh(1'b0, n);
      checkVal("init_pll_rst_width", n, T_RST);

      for (int i = 0; i < 10; i++) begin
         for (int s = 0; s < vecs[i].steps; s++) applyStimulus(vecs[i].lock, 1'b0);
         checkVal($sformatf("vec%0d_pll_rst", i), pll_rst, vecs[i].expPllRst);
         checkVal($sformatf("vec%0d_dom_rst_n", i), dom_rst_n, vecs[i].expDom);
         checkVal($sformatf("vec%0d_ready", i), ready, vecs[i].expReady);
      end

      // Lock loss in RUN: domains drop three cycles after pll_locked falls.
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkVal("loss_ready_before", ready, 1);
      applyStimulus(1'b0, 1'b0);
      checkVal("loss_dom_rst_n", dom_rst_n, 0);
      checkVal("loss_ready", ready, 0);
      checkVal("loss_pll_rst", pll_rst, 1);
      checkVal("loss_retry_cnt", retry_cnt, 0);
`ifdef PLLSEQ_LOSS_COUNT_EN
      checkVal("loss_lock_loss_cnt", lock_loss_cnt, 1);
`endif
      measureHigh(1'b0, n);
      checkVal("loss_pll_rst_width", n, T_RST);

      // Glitchy lock: high 5, low 1, then steady; release 8+2 cycles after final rise.
      repeat (5) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      repeat (9) applyStimulus(1'b1, 1'b0);
      checkVal("glitch_dom_before", dom_rst_n, 0);
      applyStimulus(1'b1, 1'b0);
      checkVal("glitch_dom_first", dom_rst_n, 5'b00001);
      repeat (10) applyStimulus(1'b1, 1'b0);
      checkVal("glitch_ready", ready, 1);

      // Timeout to fault: three 100-cycle attempts with lock held low.
      repeat (3) applyStimulus(1'b0, 1'b0);
      measureHigh(1'b0, n);
      for (int a = 1; a <= N_RETRY; a++) begin
         measureLow(n);
         checkVal($sformatf("tmo%0d_wait_len", a), n, T_TMO);
         checkVal($sformatf("tmo%0d_retry_cnt", a), retry_cnt, a);
         if (a < N_RETRY) begin
            measureHigh(1'b0, n);
            checkVal($sformatf("tmo%0d_pll_rst_width", a), n, T_RST);
         end
      end
      checkVal("fault_flag", fault, 1);
      repeat (10) applyStimulus(1'b0, 1'b0);
      checkVal("fault_hold", fault, 1);
      checkVal("fault_pll_rst", pll_rst, 1);
      checkVal("fault_dom_rst_n", dom_rst_n, 0);
      checkVal("fault_retry_cnt", retry_cnt, N_RETRY);

      // Recovery from FAULT with a one-cycle req_reset pulse.
      applyStimulus(1'b0, 1'b1);
      checkVal("recover_fault", fault, 0);
      checkVal("recover_retry_cnt", retry_cnt, 0);
      checkVal("recover_pll_rst", pll_rst, 1);
      measureHigh(1'b1, n);
      checkVal("recover_pll_rst_width", n, T_RST);
      waitReady(n);
      checkVal("recover_ready_latency", n, T_STAB + (N_DOM - 1) * T_STAG + 1);

      // req_reset in the same cycle as the third timeout's terminal count.
      repeat (3) applyStimulus(1'b0, 1'b0);
      measureHigh(1'b0, n);
      measureLow(n);
      measureHigh(1'b0, n);
      measureLow(n);
      checkVal("simul_retry_before", retry_cnt, 2);
      measureHigh(1'b0, n);
      repeat (T_TMO - 1) applyStimulus(1'b0, 1'b0);
      checkVal("simul_still_waiting", pll_rst, 0);
      applyStimulus(1'b0, 1'b1);
      checkVal("simul_retry_cnt", retry_cnt, 0);
      checkVal("simul_fault", fault, 0);
      checkVal("simul_pll_rst", pll_rst, 1);
      measureHigh(1'b1, n);
      checkVal("simul_pll_rst_width", n, T_RST);
      waitReady(n);
      checkVal("simul_ready_latency", n, T_STAB + (N_DOM - 1) * T_STAG + 1);

      // Asynchronous reset in the middle of RUN takes effect without a clock edge.
      @(posedge refclk);
      #3;
      rst_n = 1'b0;
      #1;
      checkVal("async_pll_rst", pll_rst, 1);
      checkVal("async_dom_rst_n", dom_rst_n, 0);
      checkVal("async_ready", ready, 0);
`ifdef PLLSEQ_LOSS_COUNT_EN
      checkVal("async_lock_loss_cnt", lock_loss_cnt, 0);
`endif
      doReset();

      // Randomized lock spans with occasional req_reset, checked every cycle.
      spanLeft = 0;
      lvl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (spanLeft == 0) begin
            spanLeft = $urandom_range(1, 60);
            lvl = ($urandom_range(0, 9) < 7);
         end
         spanLeft--;
         applyStimulus(lvl, ($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
